// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory/writeback stage.
// Load/store funct3 codes, stage FSM states, latched request.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } mem_wb_state_t;

  typedef struct packed {
    logic [4:0] rd_s;
    logic       regf_we;
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] offset;
  } mem_wb_req_t;

endpackage

// File: rtl/mem_wb_stage_load_store_align.sv
// Byte-lane masks, store shifting, load extraction/extension.
// Purely combinational; misaligned flags accesses that must be dropped.
module load_store_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic        is_byte;
  logic        is_half;
  logic [3:0]  mask;
  logic [31:0] lane;

  always_comb begin
    is_byte = funct3[1:0] == 2'b00;
    is_half = funct3[1:0] == 2'b01;
    mask = 4'b1111;
    unique case (1'b1)
      is_byte: mask = 4'b0001 << offset;
      is_half: mask = 4'b0011 << offset;
      default: mask = 4'b1111;
    endcase
    misaligned = (is_half && offset == 2'd3)
              || (!is_byte && !is_half && offset != 2'd0);
    lane = rdata >> {offset, 3'b000};
    load_val = lane;
    case (funct3)
      F3_LB:   load_val = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   load_val = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  load_val = {24'd0, lane[7:0]};
      F3_LHU:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  assign rmask = mask;
  assign wmask = mask;
  assign wdata = store_data << {offset, 3'b000};

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I memory-access / writeback stage with registered retire.
// Optional retire trace ports under MEM_WB_RVFI_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_ADDR_W = 32,
  parameter int ORDER_W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_alu_result,
  input  logic [31:0]            in_store_data,
  input  logic [4:0]             in_rd_s,
  input  logic                   in_regf_we,
  input  logic                   in_mem_read,
  input  logic                   in_mem_write,
  input  logic [2:0]             in_funct3,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]             dmem_rmask,
  output logic [3:0]             dmem_wmask,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic                   valid_write,
  output logic                   regf_we,
  output logic [4:0]             rd_s,
  output logic [31:0]            rd_v,
  output logic                   misaligned
`ifdef MEM_WB_RVFI_EN
  ,
  output logic                   commit_valid,
  output logic [ORDER_W-1:0]     commit_order,
  output logic [31:0]            commit_pc,
  output logic [31:0]            commit_mem_addr,
  output logic [3:0]             commit_mem_rmask,
  output logic [3:0]             commit_mem_wmask,
  output logic [31:0]            commit_mem_rdata,
  output logic [31:0]            commit_mem_wdata
`endif
);

  mem_wb_state_t state;
  mem_wb_req_t   req;

  logic        idle;
  logic        is_mem;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_rmask;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;
  logic [31:0] addr_word;

  assign idle      = state == IDLE;
  assign in_ready  = idle;
  assign is_mem    = in_mem_read || in_mem_write;
  assign addr_word = {in_alu_result[31:2], 2'b00};

  // Accept path decodes the incoming op; wait path the latched one.
  assign al_f3  = idle ? in_funct3 : req.funct3;
  assign al_off = idle ? in_alu_result[1:0] : req.offset;

  load_store_align u_align (
    .funct3     (al_f3),
    .offset     (al_off),
    .store_data (in_store_data),
    .rdata      (dmem_rdata),
    .rmask      (al_rmask),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .load_val   (al_load),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req         <= '0;
      dmem_addr   <= '0;
      dmem_rmask  <= '0;
      dmem_wmask  <= '0;
      dmem_wdata  <= '0;
      valid_write <= 1'b0;
      regf_we     <= 1'b0;
      rd_s        <= '0;
      rd_v        <= '0;
      misaligned  <= 1'b0;
    end else begin
      valid_write <= 1'b0;
      regf_we     <= 1'b0;
      rd_s        <= '0;
      rd_v        <= '0;
      misaligned  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              valid_write <= 1'b1;
              regf_we     <= in_regf_we && in_rd_s != 5'd0;
              rd_s        <= in_rd_s;
              rd_v        <= in_alu_result;
            end else if (al_mis) begin
              valid_write <= 1'b1;
              misaligned  <= 1'b1;
            end else begin
              req.rd_s    <= in_rd_s;
              req.regf_we <= in_regf_we;
              req.is_load <= in_mem_read;
              req.funct3  <= in_funct3;
              req.offset  <= in_alu_result[1:0];
              dmem_addr   <= DMEM_ADDR_W'(addr_word);
              dmem_rmask  <= in_mem_read ? al_rmask : 4'd0;
              dmem_wmask  <= in_mem_read ? 4'd0 : al_wmask;
              dmem_wdata  <= in_mem_read ? 32'd0 : al_wdata;
              state       <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_resp) begin
            valid_write <= 1'b1;
            if (req.is_load) begin
              regf_we <= req.regf_we && req.rd_s != 5'd0;
              rd_s    <= req.rd_s;
              rd_v    <= al_load;
            end
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_WB_RVFI_EN
  logic [ORDER_W-1:0] order;
  logic [31:0]        req_pc;
  logic               fire;

  assign fire = idle ? (in_valid && (!is_mem || al_mis)) : dmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      order            <= '0;
      req_pc           <= '0;
      commit_valid     <= 1'b0;
      commit_order     <= '0;
      commit_pc        <= '0;
      commit_mem_addr  <= '0;
      commit_mem_rmask <= '0;
      commit_mem_wmask <= '0;
      commit_mem_rdata <= '0;
      commit_mem_wdata <= '0;
    end else begin
      commit_valid <= fire;
      if (idle && in_valid) req_pc <= in_pc;
      if (fire) begin
        commit_order <= order;
        order        <= order + 1'b1;
        commit_pc    <= idle ? in_pc : req_pc;
        if (idle) begin
          commit_mem_addr  <= '0;
          commit_mem_rmask <= '0;
          commit_mem_wmask <= '0;
          commit_mem_rdata <= '0;
          commit_mem_wdata <= '0;
        end else begin
          commit_mem_addr  <= 32'(dmem_addr);
          commit_mem_rmask <= dmem_rmask;
          commit_mem_wmask <= dmem_wmask;
          commit_mem_rdata <= req.is_load ? dmem_rdata : 32'd0;
          commit_mem_wdata <= dmem_wdata;
        end
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for single-cycle
// retires plus hand sequences for dmem waits and reset.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd_s;
  logic        in_regf_we;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        valid_write;
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;
  logic        misaligned;
`ifdef MEM_WB_RVFI_EN
  logic        commit_valid;
  logic [63:0] commit_order;
  logic [31:0] commit_pc;
  logic [31:0] commit_mem_addr;
  logic [3:0]  commit_mem_rmask;
  logic [3:0]  commit_mem_wmask;
  logic [31:0] commit_mem_rdata;
  logic [31:0] commit_mem_wdata;
`endif

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_rd_s       (in_rd_s),
    .in_regf_we    (in_regf_we),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_funct3     (in_funct3),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .valid_write   (valid_write),
    .regf_we       (regf_we),
    .rd_s          (rd_s),
    .rd_v          (rd_v),
    .misaligned    (misaligned)
`ifdef MEM_WB_RVFI_EN
    ,
    .commit_valid     (commit_valid),
    .commit_order     (commit_order),
    .commit_pc        (commit_pc),
    .commit_mem_addr  (commit_mem_addr),
    .commit_mem_rmask (commit_mem_rmask),
    .commit_mem_wmask (commit_mem_wmask),
    .commit_mem_rdata (commit_mem_rdata),
    .commit_mem_wdata (commit_mem_wdata)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_idle();
    in_valid      = 1'b0;
    in_pc         = '0;
    in_alu_result = '0;
    in_store_data = '0;
    in_rd_s       = '0;
    in_regf_we    = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_funct3     = '0;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_v;
    logic        e_mis;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    chk({p, " valid_write"}, 32'(valid_write), 32'd1);
    chk({p, " regf_we"}, 32'(regf_we), 32'(v.e_we));
    chk({p, " rd_s"}, 32'(rd_s), 32'(v.e_rd));
    chk({p, " rd_v"}, rd_v, v.e_v);
    chk({p, " misaligned"}, 32'(misaligned), 32'(v.e_mis));
    chk({p, " in_ready"}, 32'(in_ready), 32'd1);
    chk({p, " rmask"}, 32'(dmem_rmask), 32'd0);
    chk({p, " wmask"}, 32'(dmem_wmask), 32'd0);
  endtask

  task automatic mem_op(
    input string       nm,
    input logic        ld,
    input logic [2:0]  f3,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input logic [31:0] rdat,
    input int          waitc,
    input logic [4:0]  rd,
    input logic        we,
    input logic [31:0] e_addr,
    input logic [3:0]  e_rm,
    input logic [3:0]  e_wm,
    input logic [31:0] e_wd,
    input logic        e_we,
    input logic [4:0]  e_rd,
    input logic [31:0] e_v
  );
    @(negedge clk);
    in_valid      = 1'b1;
    in_pc         = 32'h0000_2000;
    in_mem_read   = ld;
    in_mem_write  = !ld;
    in_funct3     = f3;
    in_alu_result = alu;
    in_store_data = sd;
    in_rd_s       = rd;
    in_regf_we    = we;
    @(negedge clk);
    drive_idle();
    for (int k = 0; k < waitc; k++) begin
      chk({nm, " wait in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, " addr"}, dmem_addr, e_addr);
      chk({nm, " rmask"}, 32'(dmem_rmask), 32'(e_rm));
      chk({nm, " wmask"}, 32'(dmem_wmask), 32'(e_wm));
      chk({nm, " wdata"}, dmem_wdata, e_wd);
      chk({nm, " wait valid_write"}, 32'(valid_write), 32'd0);
      if (k == waitc - 1) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rdat;
      end
      @(negedge clk);
    end
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    chk({nm, " valid_write"}, 32'(valid_write), 32'd1);
    chk({nm, " regf_we"}, 32'(regf_we), 32'(e_we));
    chk({nm, " rd_s"}, 32'(rd_s), 32'(e_rd));
    chk({nm, " rd_v"}, rd_v, e_v);
    chk({nm, " misaligned"}, 32'(misaligned), 32'd0);
    chk({nm, " done rmask"}, 32'(dmem_rmask), 32'd0);
    chk({nm, " done wmask"}, 32'(dmem_wmask), 32'd0);
    chk({nm, " done in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    chk({nm, " after valid_write"}, 32'(valid_write), 32'd0);
  endtask

  initial begin
    // alu, rd, we, mr, mw, f3, e_we, e_rd, e_v, e_mis
    vecs[0] = '{32'h0000_00FF, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0,
                1'b1, 5'd5, 32'h0000_00FF, 1'b0};
    vecs[1] = '{32'h0000_0007, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0,
                1'b0, 5'd0, 32'h0000_0007, 1'b0};
    vecs[2] = '{32'h0000_1234, 5'd3, 1'b0, 1'b0, 1'b0, 3'd0,
                1'b0, 5'd3, 32'h0000_1234, 1'b0};
    vecs[3] = '{32'h0000_0006, 5'd4, 1'b1, 1'b1, 1'b0, F3_LW,
                1'b0, 5'd0, 32'h0, 1'b1};
    vecs[4] = '{32'h0000_0003, 5'd4, 1'b1, 1'b1, 1'b0, F3_LH,
                1'b0, 5'd0, 32'h0, 1'b1};
    vecs[5] = '{32'h0000_0011, 5'd0, 1'b0, 1'b0, 1'b1, F3_SW,
                1'b0, 5'd0, 32'h0, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 3'd0,
                1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};

    rst        = 1'b1;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset valid_write", 32'(valid_write), 32'd0);
    chk("reset regf_we", 32'(regf_we), 32'd0);
    chk("reset rmask", 32'(dmem_rmask), 32'd0);
    chk("reset wmask", 32'(dmem_wmask), 32'd0);
    chk("reset addr", dmem_addr, 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);

    // Back-to-back: check vector i-1 while offering vector i.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(i - 1, vecs[i-1]);
      if (i < NV) begin
        in_valid      = 1'b1;
        in_pc         = 32'h0000_1000 + 32'(i) * 4;
        in_alu_result = vecs[i].alu;
        in_store_data = 32'hDEAD_0000;
        in_rd_s       = vecs[i].rd;
        in_regf_we    = vecs[i].we;
        in_mem_read   = vecs[i].mr;
        in_mem_write  = vecs[i].mw;
        in_funct3     = vecs[i].f3;
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    chk("idle valid_write", 32'(valid_write), 32'd0);

    mem_op("lb", 1'b1, F3_LB, 32'h1000_0003, 32'h0, 32'h8000_0000, 3,
           5'd7, 1'b1, 32'h1000_0000, 4'b1000, 4'b0000, 32'h0,
           1'b1, 5'd7, 32'hFFFF_FF80);
    mem_op("sh", 1'b0, F3_SH, 32'h2000_0002, 32'h0000_ABCD, 32'h0, 2,
           5'd9, 1'b1, 32'h2000_0000, 4'b0000, 4'b1100, 32'hABCD_0000,
           1'b0, 5'd0, 32'h0);
    mem_op("lbu", 1'b1, F3_LBU, 32'h3000_0001, 32'h0, 32'h1234_8000, 1,
           5'd8, 1'b1, 32'h3000_0000, 4'b0010, 4'b0000, 32'h0,
           1'b1, 5'd8, 32'h0000_0080);
    mem_op("lhu", 1'b1, F3_LHU, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 1,
           5'd10, 1'b1, 32'h0000_0100, 4'b1100, 4'b0000, 32'h0,
           1'b1, 5'd10, 32'h0000_BEEF);
    mem_op("lh off1", 1'b1, F3_LH, 32'h0000_0005, 32'h0, 32'h009A_BC00, 2,
           5'd11, 1'b1, 32'h0000_0004, 4'b0110, 4'b0000, 32'h0,
           1'b1, 5'd11, 32'hFFFF_9ABC);
    mem_op("lw x0", 1'b1, F3_LW, 32'h4000_0004, 32'h0, 32'hDEAD_BEEF, 1,
           5'd0, 1'b1, 32'h4000_0004, 4'b1111, 4'b0000, 32'h0,
           1'b0, 5'd0, 32'hDEAD_BEEF);
    mem_op("sb", 1'b0, F3_SB, 32'h0000_0003, 32'h0000_00A5, 32'h0, 1,
           5'd0, 1'b0, 32'h0000_0000, 4'b0000, 4'b1000, 32'hA500_0000,
           1'b0, 5'd0, 32'h0);
    mem_op("sw", 1'b0, F3_SW, 32'h0000_0040, 32'h1234_5678, 32'h0, 4,
           5'd0, 1'b0, 32'h0000_0040, 4'b0000, 4'b1111, 32'h1234_5678,
           1'b0, 5'd0, 32'h0);

    // Stray response while idle must not retire anything.
    @(negedge clk);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("idle resp valid_write", 32'(valid_write), 32'd0);
    chk("idle resp in_ready", 32'(in_ready), 32'd1);

    // Reset while a load is pending, then a late response.
    @(negedge clk);
    in_valid      = 1'b1;
    in_mem_read   = 1'b1;
    in_funct3     = F3_LW;
    in_alu_result = 32'h0000_0100;
    in_rd_s       = 5'd12;
    in_regf_we    = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("rst pend rmask", 32'(dmem_rmask), 32'hF);
    chk("rst pend in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst rmask", 32'(dmem_rmask), 32'd0);
    chk("rst addr", dmem_addr, 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst valid_write", 32'(valid_write), 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("late resp valid_write", 32'(valid_write), 32'd0);
    chk("late resp regf_we", 32'(regf_we), 32'd0);
    chk("late resp in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
